// File: rtl/data_mem_unit_pkg.sv
// Shared types and constants for the memory-stage data unit.
// The NB_* defaults match the control unit's data/address sizing.
package data_mem_unit_pkg;

  localparam int NB_DATA_DEF      = 32;
  localparam int NB_ADDR_DEF      = 5;
  localparam int NB_BYTE_ADDR_DEF = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2,
    W_NONE = 2'd3
  } width_e;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Word beats halfword beats byte when several enables are raised together.
  function automatic width_e width_sel(input logic byte_en, input logic half_en,
                                       input logic word_en);
    if (word_en)      return W_WORD;
    else if (half_en) return W_HALF;
    else if (byte_en) return W_BYTE;
    else              return W_NONE;
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the pipeline memory stage and data_mem_unit.
interface data_mem_unit_if #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_BYTE_ADDR = 32
) ();
  // No backpressure: a request is taken on any edge where the unit is ready,
  // i_enable is high and a read or write is asserted; o_read_valid and
  // o_misaligned are single-cycle pulses registered on that same edge.
  logic                    i_enable;
  logic                    i_mem_read;
  logic                    i_mem_write;
  logic                    i_byte_en;
  logic                    i_halfword_en;
  logic                    i_word_en;
  logic                    i_unsigned;
  logic [NB_BYTE_ADDR-1:0] i_address;
  logic [NB_DATA-1:0]      i_write_data;
  logic [NB_ADDR-1:0]      i_debug_addr;
  logic [NB_DATA-1:0]      o_read_data;
  logic                    o_read_valid;
  logic                    o_misaligned;
  logic                    o_ready;
  logic [NB_DATA-1:0]      o_debug_data;

  modport slave (
    input  i_enable, i_mem_read, i_mem_write, i_byte_en, i_halfword_en,
           i_word_en, i_unsigned, i_address, i_write_data, i_debug_addr,
    output o_read_data, o_read_valid, o_misaligned, o_ready, o_debug_data
  );

  modport master (
    output i_enable, i_mem_read, i_mem_write, i_byte_en, i_halfword_en,
           i_word_en, i_unsigned, i_address, i_write_data, i_debug_addr,
    input  o_read_data, o_read_valid, o_misaligned, o_ready, o_debug_data
  );
endinterface

// File: rtl/data_mem_unit_lane_align.sv
// Little-endian lane merge for stores, lane extract/extend for loads, and
// alignment check. Lane logic is built around a 32-bit, four-byte word.
module mem_lane_align
  import data_mem_unit_pkg::*;
(
  input  width_e      width_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);
  logic [1:0]  lane;
  logic [3:0]  mask;
  logic [31:0] wr_shift;
  logic [31:0] rd_shift;

  always_comb begin
    lane = 2'd0;
    mask = 4'b0000;
    case (width_i)
      W_BYTE: begin lane = offset_i;              mask = LANE_MASK_BYTE << offset_i; end
      W_HALF: begin lane = {offset_i[1], 1'b0};   mask = LANE_MASK_HALF << {offset_i[1], 1'b0}; end
      W_WORD: begin lane = 2'd0;                  mask = LANE_MASK_WORD; end
      default: begin lane = 2'd0;                 mask = 4'b0000; end
    endcase

    wr_shift = wdata_i << {lane, 3'b000};
    rd_shift = old_word_i >> {lane, 3'b000};

    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = mask[i] ? wr_shift[8*i +: 8] : old_word_i[8*i +: 8];
    end

    case (width_i)
      W_BYTE:  load_o = {{24{~unsigned_i & rd_shift[7]}}, rd_shift[7:0]};
      W_HALF:  load_o = {{16{~unsigned_i & rd_shift[15]}}, rd_shift[15:0]};
      W_WORD:  load_o = rd_shift;
      default: load_o = 32'd0;
    endcase

    misaligned_o = ((width_i == W_HALF) && offset_i[0]) ||
                   ((width_i == W_WORD) && (offset_i != 2'd0));
  end
endmodule

// File: rtl/data_mem_unit.sv
// Memory-stage data RAM: clears itself after reset, then serves sub-word
// loads/stores from the control unit and a debug read while halted.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int NB_ADDR      = NB_ADDR_DEF,
  parameter int NB_BYTE_ADDR = NB_BYTE_ADDR_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  data_mem_unit_if.slave  bus,
  output state_e          o_state
);
  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0] read_data_q, read_data_d;
  logic               read_valid_q, read_valid_d;
  logic               misaligned_q, misaligned_d;
  logic [NB_DATA-1:0] debug_data_q, debug_data_d;

  logic [NB_ADDR-1:0] idx;
  width_e             width;
  logic [NB_DATA-1:0] merged, load_val;
  logic               mis_chk, access, do_store, do_load;
  logic               ram_we;
  logic [NB_ADDR-1:0] ram_waddr;
  logic [NB_DATA-1:0] ram_wdata;
  logic               unused_addr;

  // Upper address bits fold away, so the RAM wraps modulo DEPTH words.
  assign idx         = bus.i_address[NB_ADDR+1:2];
  assign unused_addr = ^bus.i_address[NB_BYTE_ADDR-1:NB_ADDR+2];
  assign width       = width_sel(bus.i_byte_en, bus.i_halfword_en, bus.i_word_en);

  mem_lane_align u_align (
    .width_i      (width),
    .offset_i     (bus.i_address[1:0]),
    .unsigned_i   (bus.i_unsigned),
    .old_word_i   (mem_q[idx]),
    .wdata_i      (bus.i_write_data),
    .merged_o     (merged),
    .load_o       (load_val),
    .misaligned_o (mis_chk)
  );

  assign access   = (state_q == ST_READY) && bus.i_enable &&
                    (bus.i_mem_read || bus.i_mem_write) && (width != W_NONE);
  assign do_store = access && !mis_chk && bus.i_mem_write;
  assign do_load  = access && !mis_chk && bus.i_mem_read && !bus.i_mem_write;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ram_we       = 1'b0;
    ram_waddr    = idx;
    ram_wdata    = merged;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    misaligned_d = 1'b0;
    debug_data_d = debug_data_q;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == NB_ADDR'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        ram_we       = do_store;
        misaligned_d = access && mis_chk;
        read_valid_d = do_load;
        if (do_load) read_data_d = load_val;
        if (!bus.i_enable) debug_data_d = mem_q[bus.i_debug_addr];
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      debug_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
      debug_data_q <= debug_data_d;
    end
  end

  // RAM contents survive reset; only the sweep clears them.
  always_ff @(posedge i_clock) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  assign bus.o_read_data  = read_data_q;
  assign bus.o_read_valid = read_valid_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_ready      = (state_q == ST_READY);
  assign bus.o_debug_data = debug_data_q;
  assign o_state          = state_q;
endmodule
